// File: rtl/register_serial_reader_pkg.sv
// ============================================================================
// Module      : register_serial_reader_pkg
// Description : Shared state encodings, default geometry and derived sizes
//               for the wide-word serial reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package register_serial_reader_pkg;

    localparam int DEFAULT_WIDTH = 66;
    localparam int DEFAULT_CHUNK = 11;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk word still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : register_serial_reader_pkg

`default_nettype wire

// File: rtl/register_serial_reader_if.sv
// ============================================================================
// Module      : register_serial_reader_if
// Description : Load and chunk-stream handshake bundle of the serial reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface register_serial_reader_if
    import register_serial_reader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
);

    logic [WIDTH-1:0] dataIn;
    logic             loadEnable;
    logic             loadReady;
    logic [CHUNK-1:0] dataOut;
    logic             outValid;
    logic             outReady;
    logic             lastChunk;
    logic             busy;

    modport master (
        output dataIn,
        output loadEnable,
        output outReady,
        input  loadReady,
        input  dataOut,
        input  outValid,
        input  lastChunk,
        input  busy
    );

    modport slave (
        input  dataIn,
        input  loadEnable,
        input  outReady,
        output loadReady,
        output dataOut,
        output outValid,
        output lastChunk,
        output busy
    );

endinterface : register_serial_reader_if

`default_nettype wire

// File: rtl/register_serial_reader_chunk_counter.sv
// ============================================================================
// Module      : register_serial_reader_chunk_counter
// Description : Beat index counter; clear on load, advance on beat, flag the
//               final chunk of the word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_serial_reader_chunk_counter
    import register_serial_reader_pkg::*;
#(
    parameter int NUM_CHUNKS = num_chunks(DEFAULT_WIDTH, DEFAULT_CHUNK),
    parameter int CNT_W      = cnt_width(NUM_CHUNKS)
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic incr,
    output logic      terminal
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_CHUNKS - 1);

    logic [CNT_W-1:0] r_count;

    assign terminal = (r_count == C_LAST);

    // Clear wins over increment so a chained reload restarts at chunk 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (incr) begin
            r_count <= terminal ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule : register_serial_reader_chunk_counter

`default_nettype wire

// File: rtl/register_serial_reader.sv
// ============================================================================
// Module      : register_serial_reader
// Description : Captures a WIDTH-bit word and returns it LSB chunk first over
//               a valid/ready stream. Optional macro
//               REGISTER_SERIAL_READER_CHAIN_EN allows a reload on the last beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_serial_reader
    import register_serial_reader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  wire logic clk,
    input  wire logic reset,
    register_serial_reader_if.slave bus
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int CNT_W      = cnt_width(NUM_CHUNKS);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_width_check
            $error("register_serial_reader: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shadow;
    logic             w_in_send;
    logic             w_terminal;
    logic             w_load_ready;
    logic             w_load_accept;
    logic             w_beat;

    assign w_in_send = (r_state == SEND);

`ifdef REGISTER_SERIAL_READER_CHAIN_EN
    // Accepting on the final beat removes the idle bubble between words.
    assign w_load_ready = !w_in_send || (w_terminal && bus.outReady);
`else
    assign w_load_ready = !w_in_send;
`endif

    assign w_load_accept = bus.loadEnable && w_load_ready;
    assign w_beat        = w_in_send && bus.outReady;

    register_serial_reader_chunk_counter #(
        .NUM_CHUNKS (NUM_CHUNKS),
        .CNT_W      (CNT_W)
    ) u_chunk_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_load_accept),
        .incr     (w_beat),
        .terminal (w_terminal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_shadow <= '0;
        end else if (w_load_accept) begin
            r_state  <= SEND;
            r_shadow <= bus.dataIn;
        end else if (w_beat) begin
            r_shadow <= r_shadow >> CHUNK;
            if (w_terminal) begin
                r_state <= IDLE;
            end
        end
    end

    // Shadow is fully shifted out by the time IDLE is re-entered, so dataOut
    // reads zero whenever outValid is low.
    assign bus.dataOut   = r_shadow[CHUNK-1:0];
    assign bus.outValid  = w_in_send;
    assign bus.busy      = w_in_send;
    assign bus.lastChunk = w_in_send && w_terminal;
    assign bus.loadReady = w_load_ready;

endmodule : register_serial_reader

`default_nettype wire

// File: tb/tb_register_serial_reader.sv
// ============================================================================
// Module      : tb_register_serial_reader
// Description : Self-checking bench for register_serial_reader against an
//               index-based reference model of the chunk stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_serial_reader;

    localparam int W = 66;
    localparam int C = 11;
    localparam int N = W / C;
`ifdef REGISTER_SERIAL_READER_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    register_serial_reader_if #(.WIDTH(W), .CHUNK(C)) bus ();

    register_serial_reader #(.WIDTH(W), .CHUNK(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_word();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    function automatic logic [C-1:0] chunk_of(input logic [W-1:0] d, input int k);
        logic [W-1:0] t;
        t = d >> (k * C);
        return t[C-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold the request until it is taken; returns in the
    // first beat cycle with loadEnable dropped and dataIn scrambled.
    task automatic load_word(input logic [W-1:0] d);
        int t;
        t = 0;
        bus.dataIn     = d;
        bus.loadEnable = 1'b1;
        #1;
        while (!bus.loadReady && t < 20) begin
            step();
            #1;
            t++;
        end
        n_cmp++;
        if (t >= 20) begin
            n_err++;
            $display("FAIL load_timeout: loadReady=%0b required 1", bus.loadReady);
        end
        @(posedge clk);
        #1;
        bus.loadEnable = 1'b0;
        bus.dataIn     = rand_word();
    endtask

    task automatic test_reset();
        logic [C+3:0] got;
        logic [C+3:0] exp;
        bus.dataIn     = '0;
        bus.loadEnable = 1'b0;
        bus.outReady   = 1'b0;
        reset          = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        exp = {1'b0, 1'b1, 1'b0, 1'b0, {C{1'b0}}};
        for (int i = 0; i < 6; i++) begin
            got = {bus.outValid, bus.loadReady, bus.busy, bus.lastChunk, bus.dataOut};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got %h required %h", i, got, exp);
            end
            step();
        end
    endtask

    task automatic test_lsb_word();
        logic [W-1:0] d;
        d = 66'h7FF;
        bus.outReady = 1'b1;
        load_word(d);
        for (int k = 0; k < N; k++) begin
            #1;
            n_cmp++;
            if ({bus.outValid, bus.busy, bus.lastChunk} !== {1'b1, 1'b1, (k == N - 1)}) begin
                n_err++;
                $display("FAIL lsb_flags[%0d]: got v%0b b%0b l%0b", k, bus.outValid, bus.busy, bus.lastChunk);
            end
            n_cmp++;
            if (bus.dataOut !== chunk_of(d, k)) begin
                n_err++;
                $display("FAIL lsb_data[%0d]: got %h required %h", k, bus.dataOut, chunk_of(d, k));
            end
            step();
        end
        #1;
        n_cmp++;
        if ({bus.outValid, bus.loadReady, bus.busy} !== 3'b010) begin
            n_err++;
            $display("FAIL lsb_done: got v%0b r%0b b%0b required v0 r1 b0", bus.outValid, bus.loadReady, bus.busy);
        end
    endtask

    task automatic test_stall_toggle();
        logic [W-1:0] d;
        int idx;
        int cyc;
        d = '0;
        for (int k = 0; k < N; k++) d = d | (W'(k + 1) << (k * C));
        bus.outReady = 1'b1;
        load_word(d);
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 4 * N) begin
            bus.outReady = (cyc % 2 == 0);
            #1;
            n_cmp++;
            if (bus.outValid !== 1'b1 || bus.dataOut !== C'(idx + 1) ||
                bus.lastChunk !== (idx == N - 1)) begin
                n_err++;
                $display("FAIL stall_beat[%0d]: got v%0b d%h l%0b required v1 d%h l%0b",
                         cyc, bus.outValid, bus.dataOut, bus.lastChunk, C'(idx + 1), (idx == N - 1));
            end
            if (bus.outReady) idx++;
            step();
            cyc++;
        end
        n_cmp++;
        if (idx != N) begin
            n_err++;
            $display("FAIL stall_timeout: got %0d beats required %0d", idx, N);
        end
        bus.outReady = 1'b1;
        #1;
        n_cmp++;
        if (bus.outValid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_done: outValid=%0b required 0", bus.outValid);
        end
    endtask

`ifndef REGISTER_SERIAL_READER_CHAIN_EN
    task automatic test_load_during_send();
        logic [W-1:0] d1;
        logic [W-1:0] ones;
        d1   = rand_word();
        ones = '1;
        bus.outReady = 1'b1;
        load_word(d1);
        bus.dataIn     = ones;
        bus.loadEnable = 1'b1;
        for (int k = 0; k < N; k++) begin
            #1;
            n_cmp++;
            if (bus.dataOut !== chunk_of(d1, k) || bus.loadReady !== 1'b0) begin
                n_err++;
                $display("FAIL ignore_load[%0d]: got d%h r%0b required d%h r0",
                         k, bus.dataOut, bus.loadReady, chunk_of(d1, k));
            end
            step();
        end
        #1;
        n_cmp++;
        if ({bus.outValid, bus.loadReady} !== 2'b01) begin
            n_err++;
            $display("FAIL ignore_idle: got v%0b r%0b required v0 r1", bus.outValid, bus.loadReady);
        end
        step();
        bus.loadEnable = 1'b0;
        for (int k = 0; k < N; k++) begin
            #1;
            n_cmp++;
            if (bus.outValid !== 1'b1 || bus.dataOut !== chunk_of(ones, k)) begin
                n_err++;
                $display("FAIL ones_word[%0d]: got v%0b d%h required v1 d%h",
                         k, bus.outValid, bus.dataOut, chunk_of(ones, k));
            end
            step();
        end
    endtask
`endif

    task automatic test_reset_midword();
        logic [W-1:0] d;
        logic [W-1:0] d2;
        logic [C+3:0] got;
        d  = rand_word();
        d2 = rand_word();
        bus.outReady = 1'b1;
        load_word(d);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++;
            if (bus.dataOut !== chunk_of(d, k)) begin
                n_err++;
                $display("FAIL mid_pre[%0d]: got %h required %h", k, bus.dataOut, chunk_of(d, k));
            end
            step();
        end
        reset = 1'b0;
        #1;
        got = {bus.outValid, bus.loadReady, bus.busy, bus.lastChunk, bus.dataOut};
        n_cmp++;
        if (got !== {1'b0, 1'b1, 1'b0, 1'b0, {C{1'b0}}}) begin
            n_err++;
            $display("FAIL mid_reset: got %h required %h", got, {1'b0, 1'b1, 1'b0, 1'b0, {C{1'b0}}});
        end
        step();
        reset = 1'b1;
        step();
        load_word(d2);
        for (int k = 0; k < N; k++) begin
            #1;
            n_cmp++;
            if (bus.outValid !== 1'b1 || bus.dataOut !== chunk_of(d2, k)) begin
                n_err++;
                $display("FAIL mid_reload[%0d]: got v%0b d%h required v1 d%h",
                         k, bus.outValid, bus.dataOut, chunk_of(d2, k));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1;
        logic [W-1:0] w2;
        bit           pending;
        bit           take;
        bit           ev;
        logic [C-1:0] ed;
        w1 = 66'h1;
        w2 = 66'h2;
        bus.outReady = 1'b1;
        load_word(w1);
        bus.dataIn     = w2;
        bus.loadEnable = 1'b1;
        pending        = 1'b1;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (CHAIN) begin
                ev = (c < 2 * N);
                ed = !ev ? '0 : (c < N) ? chunk_of(w1, c) : chunk_of(w2, c - N);
            end else begin
                ev = (c < N) || (c > N && c <= 2 * N);
                ed = !ev ? '0 : (c < N) ? chunk_of(w1, c) : chunk_of(w2, c - N - 1);
            end
            n_cmp++;
            if (bus.outValid !== ev || bus.dataOut !== ed) begin
                n_err++;
                $display("FAIL b2b[%0d]: got v%0b d%h required v%0b d%h", c, bus.outValid, bus.dataOut, ev, ed);
            end
            take = pending && bus.loadReady;
            step();
            if (take) begin
                bus.loadEnable = 1'b0;
                pending        = 1'b0;
            end
        end
        bus.loadEnable = 1'b0;
    endtask

    task automatic test_random();
        bit           ev;
        int           ei;
        logic [W-1:0] ew;
        bit           er;
        logic [C-1:0] ed;
        logic [C+3:0] got;
        logic [C+3:0] exp;
        ev = 1'b0;
        ei = 0;
        ew = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            bus.loadEnable = ($urandom() % 3 == 0);
            bus.dataIn     = rand_word();
            bus.outReady   = ($urandom() % 4 != 0);
            #1;
            er  = !ev || (CHAIN && ei == N - 1 && bus.outReady);
            ed  = ev ? chunk_of(ew, ei) : '0;
            exp = {er, ev, ev, (ev && ei == N - 1), ed};
            got = {bus.loadReady, bus.outValid, bus.busy, bus.lastChunk, bus.dataOut};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random[%0d]: got %h required %h", cyc, got, exp);
            end
            if (bus.loadEnable && er) begin
                ew = bus.dataIn;
                ei = 0;
                ev = 1'b1;
            end else if (ev && bus.outReady) begin
                if (ei == N - 1) ev = 1'b0;
                else ei++;
            end
            step();
        end
        bus.loadEnable = 1'b0;
        bus.outReady   = 1'b1;
        repeat (N + 2) step();
    endtask

    initial begin
        bus.dataIn     = '0;
        bus.loadEnable = 1'b0;
        bus.outReady   = 1'b0;
        test_reset();
        test_lsb_word();
        test_stall_toggle();
`ifndef REGISTER_SERIAL_READER_CHAIN_EN
        test_load_during_send();
`endif
        test_reset_midword();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_register_serial_reader

`default_nettype wire
